// File: rtl/mem_access.sv
// mem_access: MIPS memory-stage load/store unit driving a req/ack data bus with stall, misalign and timeout flags
module mem_access #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  memSize,
  input  logic        memUnsigned,
  input  logic [31:0] ALUResult,
  input  logic [31:0] storeData,
  output logic [31:0] readData,
  output logic        stall,
  output logic        misaligned,
  output logic        busError,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [3:0]  memBe,
  output logic [31:0] memWData,
  input  logic [31:0] memRData,
  input  logic        memAck
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_nxt;
  logic [15:0] cnt;
  logic [1:0] lat_off, lat_size;
  logic lat_uns;
  logic free, op, aligned, accept, timeout;
  logic [3:0] be;
  logic [31:0] wdata, sh, ld;
  always_comb begin
    free = state != REQ;
    op = MemRead | MemWrite;
    aligned = memSize == 2'd0 ? 1'b1 : memSize == 2'd1 ? !ALUResult[0] : ALUResult[1:0] == 2'd0;
    accept = free & op & aligned;
    misaligned = rst_n & free & op & !aligned;
    stall = !free | accept;
    timeout = !free & !memAck & (ACK_TIMEOUT != 0) & ({1'b0, cnt} + 17'd1 == 17'(ACK_TIMEOUT));
    state_nxt = accept ? REQ : free ? IDLE : memAck ? DONE : timeout ? IDLE : REQ;
    be = memSize == 2'd0 ? 4'b0001 << ALUResult[1:0] :
         memSize == 2'd1 ? (ALUResult[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = memSize == 2'd0 ? {4{storeData[7:0]}} :
            memSize == 2'd1 ? {2{storeData[15:0]}} : storeData;
    sh = memRData >> {lat_off, 3'b000};
    ld = lat_size == 2'd0 ? {{24{!lat_uns & sh[7]}}, sh[7:0]} :
         lat_size == 2'd1 ? {{16{!lat_uns & sh[15]}}, sh[15:0]} : memRData;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      readData <= '0;
      busError <= 1'b0;
      memReq <= 1'b0;
      memWe <= 1'b0;
      memAddr <= '0;
      memBe <= '0;
      memWData <= '0;
      lat_off <= '0;
      lat_size <= '0;
      lat_uns <= 1'b0;
    end else begin
      state <= state_nxt;
      busError <= timeout;
      if (accept) begin
        memReq <= 1'b1;
        memWe <= !MemRead;
        memAddr <= {ALUResult[31:2], 2'b00};
        memBe <= be;
        memWData <= wdata;
        lat_off <= ALUResult[1:0];
        lat_size <= memSize;
        lat_uns <= memUnsigned;
        cnt <= '0;
      end else if (!free) begin
        if (memAck | timeout) memReq <= 1'b0;
        if (memAck & !memWe) readData <= ld;
        cnt <= memAck ? '0 : cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed transactions against a timeline model of the load/store unit, checked every cycle
module tb_mem_access;
  localparam int TO = 4;
  logic clk = 0, rst_n = 0, MemRead = 0, MemWrite = 0, memUnsigned = 0, memAck = 0;
  logic [1:0] memSize = 0;
  logic [31:0] ALUResult = 0, storeData = 0, memRData = 0;
  logic [31:0] readData, memAddr, memWData;
  logic [3:0] memBe;
  logic stall, misaligned, busError, memReq, memWe;
  int total = 0, bad = 0, stall_cnt = 0, req_cnt = 0;
  logic chk_on = 0;
  logic [31:0] e_rd = 0, e_addr = 0, e_wd = 0;
  logic [3:0] e_be = 0;
  logic e_we = 0, e_req = 0, e_stall = 0, e_mis = 0, e_berr = 0, e_busv = 1;

  mem_access #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite), .memSize(memSize),
    .memUnsigned(memUnsigned), .ALUResult(ALUResult), .storeData(storeData), .readData(readData),
    .stall(stall), .misaligned(misaligned), .busError(busError), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memBe(memBe), .memWData(memWData), .memRData(memRData), .memAck(memAck)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) if (chk_on) begin
    chk("readData", readData, e_rd);
    chk("memReq", 32'(memReq), 32'(e_req));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("misaligned", 32'(misaligned), 32'(e_mis));
    chk("busError", 32'(busError), 32'(e_berr));
    if (e_busv) begin
      chk("memAddr", memAddr, e_addr);
      chk("memWe", 32'(memWe), 32'(e_we));
      chk("memBe", 32'(memBe), 32'(e_be));
      chk("memWData", memWData, e_wd);
    end
    stall_cnt += 32'(stall);
    req_cnt += 32'(memReq);
  end

  function automatic logic [31:0] load_val(input logic [31:0] d, input logic [1:0] a,
                                           input logic [1:0] sz, input logic u);
    logic [7:0] b;
    logic [15:0] h;
    b = 8'(d >> (8 * a));
    h = 16'(d >> (16 * a[1]));
    if (sz == 0) return u ? 32'(b) : 32'($signed(b));
    if (sz == 1) return u ? 32'(h) : 32'($signed(h));
    return d;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // waits = REQ cycles before the ack cycle; negative or >= TO means never ack
  task automatic mem_op(input logic rd, input logic wr, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] sd, input int waits,
                        input logic [31:0] rdat);
    logic al;
    al = sz == 0 || (sz == 1 ? !a[0] : a[1:0] == 0);
    MemRead = rd; MemWrite = wr; memSize = sz; memUnsigned = u; ALUResult = a; storeData = sd;
    e_mis = !al; e_stall = al; e_req = 0; e_busv = 0;
    step;
    if (!al) begin
      e_mis = 0; MemRead = 0; MemWrite = 0;
      return;
    end
    e_addr = {a[31:2], 2'b00};
    e_we = !rd;
    e_be = sz == 0 ? 4'(1 << a[1:0]) : sz == 1 ? (a[1] ? 4'hc : 4'h3) : 4'hf;
    e_wd = sz == 0 ? {4{sd[7:0]}} : sz == 1 ? {2{sd[15:0]}} : sd;
    e_req = 1; e_busv = 1;
    for (int k = 1; k <= TO; k++) begin
      memAck = (k == waits + 1);
      memRData = memAck ? rdat : $urandom;
      step;
      if (memAck) begin
        memAck = 0;
        if (rd) e_rd = load_val(rdat, a[1:0], sz, u);
        break;
      end
    end
    MemRead = 0; MemWrite = 0; e_req = 0; e_stall = 0; e_busv = 0;
    if (waits < 0 || waits >= TO) begin
      e_berr = 1;
      step;
      e_berr = 0;
    end
  endtask

  initial begin
    chk_on = 1;
    step; step;
    rst_n = 1; e_busv = 0;
    step;
    stall_cnt = 0;
    mem_op(1, 0, 2, 0, 32'h100, 0, 2, 32'hDEADBEEF);
    chk("word_rd", readData, 32'hDEADBEEF);
    chk("word_addr", memAddr, 32'h100);
    chk("word_be", 32'(memBe), 32'hf);
    chk("word_stall", stall_cnt, 4);
    step;
    mem_op(1, 0, 0, 0, 32'h203, 0, 0, 32'h80FF7F01);
    chk("sbyte", readData, 32'hFFFFFF80);
    mem_op(1, 0, 0, 1, 32'h203, 0, 1, 32'h80FF7F01);
    chk("ubyte", readData, 32'h00000080);
    mem_op(1, 0, 1, 0, 32'h202, 0, 0, 32'h80FF7F01);
    chk("shalf", readData, 32'hFFFF80FF);
    mem_op(1, 0, 1, 1, 32'h200, 0, 3, 32'h80FF7F01);
    chk("uhalf", readData, 32'h00007F01);
    mem_op(0, 1, 0, 0, 32'h301, 32'h000000AB, 1, 0);
    chk("sb_we", 32'(memWe), 1);
    chk("sb_be", 32'(memBe), 32'h2);
    chk("sb_wd", memWData, 32'hABABABAB);
    chk("sb_rd", readData, 32'h00007F01);
    mem_op(0, 1, 1, 0, 32'h302, 32'h00001234, 0, 0);
    chk("sh_be", 32'(memBe), 32'hc);
    chk("sh_wd", memWData, 32'h12341234);
    step;
    req_cnt = 0; stall_cnt = 0;
    mem_op(1, 0, 2, 0, 32'h102, 0, 0, 32'h11111111);
    mem_op(1, 1, 1, 0, 32'h105, 0, 0, 32'h22222222);
    step;
    chk("mis_req", req_cnt, 0);
    chk("mis_stall", stall_cnt, 0);
    chk("mis_rd", readData, 32'h00007F01);
    req_cnt = 0;
    mem_op(1, 0, 2, 0, 32'h400, 0, -1, 0);
    chk("to_req", req_cnt, TO);
    mem_op(1, 0, 2, 0, 32'h404, 0, 0, 32'h55AA00FF);
    chk("after_to", readData, 32'h55AA00FF);
    step;
    stall_cnt = 0;
    mem_op(1, 1, 2, 1, 32'h600, 0, 0, 32'hCAFEF00D);
    mem_op(0, 1, 2, 0, 32'h604, 32'h87654321, 0, 0);
    chk("b2b_stall", stall_cnt, 4);
    chk("b2b_rd", readData, 32'hCAFEF00D);
    memAck = 1; memRData = 32'h0BADBAD0;
    step;
    memAck = 0;
    step;
    MemRead = 1; memSize = 2; memUnsigned = 0; ALUResult = 32'h500; storeData = 32'h77;
    e_stall = 1;
    step;
    e_req = 1; e_busv = 1; e_addr = 32'h500; e_we = 0; e_be = 4'hf; e_wd = 32'h77;
    rst_n = 0;
    step;
    rst_n = 1; MemRead = 0;
    e_rd = 0; e_addr = 0; e_be = 0; e_wd = 0; e_we = 0; e_req = 0; e_stall = 0;
    step;
    chk("rst_rd", readData, 0);
    e_busv = 0;
    step;
    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-stage load/store unit for the MIPS pipeline. It takes the EX/MEM address (ALU result), store data and control, runs a multi-cycle request/acknowledge transaction on the data-memory bus, and produces the aligned, extended `readData` word consumed by the write-back select. While a transaction is outstanding it stalls the pipeline. It also flags misaligned accesses and bus timeouts.

## Interface
Parameters:
- `ACK_TIMEOUT`, 255: maximum cycles to wait for `memAck` in REQ. 0 disables the timeout. Range 0..65535.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `MemRead`  in  1  load request from EX/MEM
- `MemWrite`  in  1  store request from EX/MEM
- `memSize`  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- `memUnsigned`  in  1  1 = zero-extend loads, 0 = sign-extend
- `ALUResult`  in  32  effective byte address
- `storeData`  in  32  store value; low bits used for byte and half
- `readData`  out  32  extended load result for write-back
- `stall`  out  1  freezes PC, IF/ID, ID/EX and EX/MEM this cycle
- `misaligned`  out  1  one-cycle pulse: misaligned access dropped
- `busError`  out  1  one-cycle pulse: ack timeout
- `memReq`  out  1  bus request, registered
- `memWe`  out  1  1 = write, registered
- `memAddr`  out  32  word address {ALUResult[31:2],2'b00}, registered
- `memBe`  out  4  byte enables, little-endian, registered
- `memWData`  out  32  lane-replicated store data, registered
- `memRData`  in  32  read data, valid with `memAck`
- `memAck`  in  1  one-cycle completion strobe

## Operation
- **States:** IDLE, REQ, DONE. Reset puts the block in IDLE and clears all outputs: `readData`=0, `memReq`=0, `memWe`=0, `memAddr`=0, `memBe`=0, `memWData`=0, `misaligned`=0, `busError`=0, timeout counter=0.
- **Accepting an op:** an op is accepted in IDLE or DONE when `MemRead|MemWrite` is high. If both are set, `MemRead` wins and the op is a load.
- **Alignment:** a word access needs `ALUResult[1:0]`=0. A half access needs `ALUResult[0]`=0.
  - Misaligned op: no bus request, `misaligned`=1 that cycle (combinational), `stall`=0, `readData` unchanged, state goes to IDLE.
- **Aligned accepted op:** latch the bus outputs, set `memReq`=1 and `memWe`=!MemRead, go to REQ.
  - Byte enables: byte = 1<<addr[1:0]; half = 4'b0011 or 4'b1100 by addr[1]; word = 4'b1111.
  - Store data lanes: byte replicated {4{sd[7:0]}}; half replicated {2{sd[15:0]}}; word as-is.
- **REQ:** `memReq` and the other bus outputs hold steady until `memAck` is seen.
  - On `memAck` for a load: select lane by the latched addr[1:0] and size, extend per latched `memUnsigned`, register into `readData`.
  - On `memAck` for any op: `memReq`=0, go to DONE.
  - `memAck` seen in IDLE or DONE is ignored.
- **Timeout:** the counter increments each REQ cycle without `memAck`. When it reaches `ACK_TIMEOUT` (if nonzero): `memReq`=0, `busError` pulses for one cycle, `readData` unchanged, go to IDLE.
- **DONE:** lasts one cycle and behaves exactly like IDLE for accepting the next op. Back-to-back memory ops therefore cost no extra idle cycle.
- **Stall:** `stall` = (REQ) OR ((IDLE|DONE) AND op present AND aligned). It is combinational, so it is high in the accept cycle.

## Timing
- **Load latency:** accepted at edge E0. `memReq` is high from E0 until the edge that samples `memAck`. `readData` is valid the cycle after that edge (DONE), when `stall` is low and the pipeline advances into WB.
- **Zero-wait memory:** if `memAck` is high in the first REQ cycle, `stall` is high for 2 cycles per access.
- **Reset mid-transaction:** `rst_n` low at an edge aborts the transaction. `memReq` drops the next cycle, with no `busError` and no `readData` update. The bench must drive the memory model idle as well.
- **Pipeline ordering:** the upstream stage must hold the EX/MEM inputs stable while `stall`=1. The block re-samples them only in IDLE or DONE.

## Test plan
- **Word load:** ALUResult=0x100, MemRead, size=10; memory acks after 3 REQ cycles with 0xDEADBEEF -> `memAddr`=0x100, `memBe`=1111, `stall` high 4 cycles, `readData`=0xDEADBEEF in DONE.
- **Byte and half extension:** memRData=0x80FF7F01.
  - Signed byte at addr 0x203 -> 0xFFFFFF80. Unsigned byte at 0x203 -> 0x00000080.
  - Signed half at 0x202 -> 0xFFFF80FF. Unsigned half at 0x200 -> 0x00007F01.
- **Stores:**
  - Byte store of 0x000000AB at 0x301 -> `memWe`=1, `memBe`=0010, `memWData`=0xABABABAB, `readData` unchanged.
  - Half store of 0x1234 at 0x302 -> `memBe`=1100, `memWData`=0x12341234.
- **Misaligned:** word load at 0x102 -> `misaligned` one-cycle pulse, `memReq` never rises, `stall`=0, `readData` keeps its prior value.
- **Timeout:** `ACK_TIMEOUT`=4, memory never acks -> `memReq` high exactly 4 cycles, `busError` one pulse, state IDLE. A later load with a prompt ack completes normally.
- **Back-to-back and reset:**
  - Load then store in consecutive accepts with zero-wait acks -> second `memReq` rises the edge after DONE, with no idle gap.
  - `rst_n` low during REQ -> all outputs 0 the next cycle, `readData`=0.
